// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM encoding, row priority
// helper and the calculator key map that the top level applies to key indices.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  // Index -> calculator code for the 4x4 board (digits, operators, clear, equals)
  localparam logic [3:0] KEY_MAP [16] = '{
    4'd1,  4'd2, 4'd3,  4'd12,
    4'd4,  4'd5, 4'd6,  4'd13,
    4'd7,  4'd8, 4'd9,  4'd14,
    4'd11, 4'd0, 4'd10, 4'd15
  };

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    return KEY_MAP[idx];
  endfunction

  // Lowest set bit wins when several rows in one column are active
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) lowest_set = 3'(i - 1);
    end
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller with press/release debounce; reports the
// confirmed key index (row*COLS + col) with single-cycle press/release pulses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SETTLE   = 4,
  parameter  int DEBOUNCE = 8,
  localparam int CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ROWS-1:0]   keyboardfil,
  output logic [COLS-1:0]   keyboardcol,
  output logic [CODE_W-1:0] KeyCode,
  output logic              KeyRead,
  output logic              KeyHeld,
  output logic              KeyRelease
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, col_next;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_d;
  logic              read_d, held_d, rel_d;
  logic [ROWS-1:0]   rs;
  logic [7:0]        rs8;
  logic [2:0]        low;

  keypad_sync #(.W(ROWS)) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (keyboardfil),
    .q     (rs)
  );

  assign rs8         = 8'(rs);
  assign low         = lowest_set(rs8);
  assign col_next    = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
  assign keyboardcol = COLS'(1) << col_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = KeyCode;
    read_d  = 1'b0;
    held_d  = KeyHeld;
    rel_d   = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d = '0;
          if (rs == '0) begin
            col_d = col_next;
          end else begin
            row_d   = ROW_W'(low);
            cnt_d   = CNT_W'(1);
            state_d = S_DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if ((rs != '0) && (low == 3'(row_q))) begin
          if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            code_d  = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);
            read_d  = 1'b1;
            held_d  = 1'b1;
            state_d = S_HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_SCAN;
          col_d   = col_next;
          cnt_d   = '0;
        end
      end
      S_HELD: begin
        // Only the captured row matters; other keys in this column are ignored
        if (!rs[row_q]) begin
          state_d = S_RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (rs[row_q]) begin
          state_d = S_HELD;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          held_d  = 1'b0;
          rel_d   = 1'b1;
          state_d = S_SCAN;
          col_d   = col_next;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_SCAN;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      KeyCode    <= '0;
      KeyRead    <= 1'b0;
      KeyHeld    <= 1'b0;
      KeyRelease <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      KeyCode    <= code_d;
      KeyRead    <= read_d;
      KeyHeld    <= held_d;
      KeyRelease <= rel_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected press/release
// events, per-DUT monitors pop and compare whenever a pulse appears.
module tb_keypad_scanner;

  typedef struct {
    bit          rel;
    int unsigned code;
    bit          exact;
    int unsigned cyc;
  } evt_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  kf1, col1, code1;
  logic        rd1, hd1, rl1;
  logic [1:0]  kf2;
  logic [7:0]  col2;
  logic [3:0]  code2;
  logic        rd2, hd2, rl2;
  logic [15:0] pk1 = '0;
  logic [15:0] pk2 = '0;
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned c0;
  evt_t        q1[$], q2[$];
  evt_t        e1, e2;

  keypad_scanner dut1 (
    .CLK(CLK), .RESET(RESET), .keyboardfil(kf1), .keyboardcol(col1),
    .KeyCode(code1), .KeyRead(rd1), .KeyHeld(hd1), .KeyRelease(rl1)
  );

  keypad_scanner #(.ROWS(2), .COLS(8)) dut2 (
    .CLK(CLK), .RESET(RESET), .keyboardfil(kf2), .keyboardcol(col2),
    .KeyCode(code2), .KeyRead(rd2), .KeyHeld(hd2), .KeyRelease(rl2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Key matrix model: a pressed key connects its column drive to its row line
  always_comb begin
    kf1 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pk1[r*4+c] && col1[c]) kf1[r] = 1'b1;
  end

  always_comb begin
    kf2 = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++)
        if (pk2[r*8+c] && col2[c]) kf2[r] = 1'b1;
  end

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic evt_t mk(input bit rel, input int unsigned code, input bit exact,
                              input int unsigned c);
    evt_t e;
    e.rel = rel; e.code = code; e.exact = exact; e.cyc = c;
    return e;
  endfunction

  task automatic check_evt(input string tag, input evt_t e, input logic rd, input logic rl,
                           input logic hd, input int unsigned code);
    check({tag, "_overlap"}, 32'(rd & rl), 0);
    check({tag, "_kind"}, 32'(rl), 32'(e.rel));
    check({tag, "_code"}, code, e.code);
    check({tag, "_held"}, 32'(hd), 32'(!e.rel));
    if (e.exact) check({tag, "_cycle"}, cyc, e.cyc);
    else         check({tag, "_not_early"}, 32'(cyc >= e.cyc), 1);
  endtask

  always @(negedge CLK) begin
    if (!RESET && (rd1 || rl1)) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1_unexpected: KeyRead=%0d KeyRelease=%0d code=%0d, required no pulse (cycle %0d)",
                 rd1, rl1, code1, cyc);
      end else begin
        e1 = q1.pop_front();
        check_evt("dut1", e1, rd1, rl1, hd1, 32'(code1));
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET && (rd2 || rl2)) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut2_unexpected: KeyRead=%0d KeyRelease=%0d code=%0d, required no pulse (cycle %0d)",
                 rd2, rl2, code2, cyc);
      end else begin
        e2 = q2.pop_front();
        check_evt("dut2", e2, rd2, rl2, hd2, 32'(code2));
      end
    end
  end

  task automatic wait_col(input bit which, input logic [7:0] v, output int unsigned c);
    int unsigned i = 0;
    string nm;
    while (((which ? col2 : {4'b0, col1}) !== v) && i < 64) begin
      @(negedge CLK);
      i++;
    end
    nm = which ? "dut2_col_reached" : "dut1_col_reached";
    check(nm, 32'(which ? col2 : {4'b0, col1}), 32'(v));
    c = cyc;
  endtask

  task automatic drain(input bit which, input int unsigned lim);
    int unsigned i = 0;
    string nm;
    while (((which ? q2.size() : q1.size()) != 0) && i < lim) begin
      @(negedge CLK);
      i++;
    end
    nm = which ? "dut2_event_timeout" : "dut1_event_timeout";
    check(nm, which ? q2.size() : q1.size(), 0);
    if (which) q2.delete();
    else       q1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_col1", 32'(col1), 1);
    check("rst_code1", 32'(code1), 0);
    check("rst_read1", 32'(rd1), 0);
    check("rst_held1", 32'(hd1), 0);
    check("rst_rel1", 32'(rl1), 0);
    check("rst_col2", 32'(col2), 1);
    RESET = 1'b0;

    // Idle scan: 4 cycles per column, both geometries
    for (int unsigned k = 0; k < 36; k++) begin
      check("idle_col1", 32'(col1), 32'(1) << ((k / 4) % 4));
      check("idle_col2", 32'(col2), 32'(1) << ((k / 4) % 8));
      @(negedge CLK);
    end

    // Clean press row 2 col 1 -> index 9
    wait_col(0, 8'h01, c0);
    pk1[9] = 1'b1;
    wait_col(0, 8'h02, c0);
    q1.push_back(mk(0, 9, 1, c0 + 11));
    drain(0, 40);
    repeat (40) @(negedge CLK);
    check("held_col_frozen", 32'(col1), 2);
    check("held_level", 32'(hd1), 1);
    pk1[9] = 1'b0;
    q1.push_back(mk(1, 9, 1, cyc + 10));
    repeat (11) @(negedge CLK);
    check("release_next_col", 32'(col1), 4);
    drain(0, 10);
    repeat (20) @(negedge CLK);
    check("code_kept", 32'(code1), 9);
    check("held_cleared", 32'(hd1), 0);

    // Press bounce on row 0 col 3 -> index 3, confirmed only once stable
    for (int unsigned t = 0; t < 7; t++) begin
      pk1[3] = ~pk1[3];
      repeat (3) @(negedge CLK);
    end
    q1.push_back(mk(0, 3, 0, cyc + 5));
    drain(0, 100);

    // Release bounce: short drop must not release
    pk1[3] = 1'b0;
    repeat (5) @(negedge CLK);
    pk1[3] = 1'b1;
    repeat (20) @(negedge CLK);
    check("rel_bounce_held", 32'(hd1), 1);
    check("rel_bounce_col", 32'(col1), 8);
    pk1[3] = 1'b0;
    q1.push_back(mk(1, 3, 1, cyc + 10));
    drain(0, 20);

    // Rows 1 and 3 of col 0: lowest row wins, then row 3 after row 1 releases
    pk1[4] = 1'b1;
    pk1[12] = 1'b1;
    q1.push_back(mk(0, 4, 0, cyc));
    drain(0, 60);
    pk1[4] = 1'b0;
    q1.push_back(mk(1, 4, 1, cyc + 10));
    q1.push_back(mk(0, 12, 1, cyc + 33));
    drain(0, 60);
    check("multi_held", 32'(hd1), 1);

    // Reset while held: immediate clear, no release pulse afterwards
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midrst_held", 32'(hd1), 0);
    check("midrst_code", 32'(code1), 0);
    check("midrst_col", 32'(col1), 1);
    check("midrst_read", 32'(rd1), 0);
    check("midrst_rel", 32'(rl1), 0);
    pk1 = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (40) @(negedge CLK);

    // 2x8 build: row 1 col 7 -> index 15 needs the 4-bit code
    wait_col(1, 8'h01, c0);
    pk2[15] = 1'b1;
    wait_col(1, 8'h80, c0);
    q2.push_back(mk(0, 15, 1, c0 + 11));
    drain(1, 40);
    repeat (10) @(negedge CLK);
    check("dut2_col_frozen", 32'(col2), 32'h80);
    pk2[15] = 1'b0;
    q2.push_back(mk(1, 15, 1, cyc + 10));
    drain(1, 20);
    repeat (5) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
